// File: rtl/pipelined_adder_elastic_if.sv
// Operand/result handshake bundle for pipelined_adder_elastic.
// master = producer/consumer side, slave = the adder.
interface pipelined_adder_elastic_if #(
   parameter int DW    = 8,
   parameter int OCC_W = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [DW-1:0]    inp1;
   logic [DW-1:0]    inp2;
   logic [1:0]       mode;
   logic             out_valid;
   logic             out_ready;
   logic [DW-1:0]    outp;
   logic             out_ovf;
   logic [OCC_W-1:0] occ;

   modport master (
      output in_valid, inp1, inp2, mode, out_ready,
      input  in_ready, out_valid, outp, out_ovf, occ
   );

   modport slave (
      input  in_valid, inp1, inp2, mode, out_ready,
      output in_ready, out_valid, outp, out_ovf, occ
   );
endinterface

// File: rtl/pipelined_adder_elastic.sv
// Elastic DW-bit adder: wrap/saturate modes resolved in stage 1, result carried
// through NUM_REG stall-able stages with a combinational ready chain.
module pipelined_adder_elastic_stage #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         ld,
   input  logic         vld_in,
   input  logic [W-1:0] d,
   output logic         vld,
   output logic [W-1:0] q
);
   // Flush drops the valid bit only; the data register keeps its contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= 1'b0;
         q   <= '0;
      end else if (flush) begin
         vld <= 1'b0;
      end else if (ld) begin
         vld <= vld_in;
         q   <= d;
      end
   end
endmodule

module pipelined_adder_elastic #(
   parameter int DW      = 8,
   parameter int NUM_REG = 4,
   parameter int OCC_W   = $clog2(NUM_REG+1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   pipelined_adder_elastic_if.slave  bus
);
   typedef struct packed {
      logic          ovf;
      logic [DW-1:0] data;
   } res_t;

   res_t                 s1;
   res_t [NUM_REG:1]     pipe;
   logic [NUM_REG:1]     vld_pipe;
   logic [NUM_REG+1:1]   rdy;
   logic [DW:0]          sum;
   logic                 sovf;
   logic                 acc;
   logic                 drain;
   logic [OCC_W-1:0]     occ_q;

   // Stage-1 arithmetic; mode is consumed here and never travels down the pipe.
   always_comb begin
      sum     = {1'b0, bus.inp1} + {1'b0, bus.inp2};
      sovf    = (bus.inp1[DW-1] == bus.inp2[DW-1]) && (sum[DW-1] != bus.inp1[DW-1]);
      s1.data = sum[DW-1:0];
      s1.ovf  = sum[DW];
      case (bus.mode)
         2'b01: if (sum[DW]) s1.data = '1;
         2'b10: begin
            s1.ovf = sovf;
            if (sovf) s1.data = bus.inp1[DW-1] ? {1'b1, {(DW-1){1'b0}}}
                                               : {1'b0, {(DW-1){1'b1}}};
         end
         2'b11: s1.ovf = sovf;
         default: ;
      endcase
   end

   // A stage can load if it is empty or the stage after it moves.
   always_comb begin
      rdy[NUM_REG+1] = bus.out_ready;
      for (int i = NUM_REG; i >= 1; i--)
         rdy[i] = !vld_pipe[i] | rdy[i+1];
   end

   assign bus.in_ready = rdy[1] & !flush & rst_n;
   assign acc          = bus.in_valid & bus.in_ready;
   assign drain        = vld_pipe[NUM_REG] & bus.out_ready;

   for (genvar i = 1; i <= NUM_REG; i++) begin : g_stg
      if (i == 1) begin : g_first
         pipelined_adder_elastic_stage #(.W($bits(res_t))) u_stg (
            .clk(clk), .rst_n(rst_n), .flush(flush), .ld(rdy[i]),
            .vld_in(acc), .d(s1), .vld(vld_pipe[i]), .q(pipe[i])
         );
      end else begin : g_rest
         pipelined_adder_elastic_stage #(.W($bits(res_t))) u_stg (
            .clk(clk), .rst_n(rst_n), .flush(flush), .ld(rdy[i]),
            .vld_in(vld_pipe[i-1]), .d(pipe[i-1]), .vld(vld_pipe[i]), .q(pipe[i])
         );
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     occ_q <= '0;
      else if (flush) occ_q <= '0;
      else begin
         case ({acc, drain})
            2'b10:   occ_q <= occ_q + 1'b1;
            2'b01:   occ_q <= occ_q - 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.out_valid = vld_pipe[NUM_REG];
   assign bus.outp      = pipe[NUM_REG].data;
   assign bus.out_ovf   = pipe[NUM_REG].ovf;
   assign bus.occ       = occ_q;
endmodule

// File: doc/pipelined_adder_elastic.md
# pipelined_adder_elastic

Parametrised successor to the fixed-latency pipelined adder: adds two DW-bit operands, with a per-transaction arithmetic mode (wrap or saturate, unsigned or signed), and carries the result through NUM_REG register stages. Adds valid/ready flow control with backpressure, an overflow flag, a synchronous flush and an occupancy count. It sits between the sequence-adder datapath and any consumer that can stall, and sustains one addition per cycle when the consumer does not stall.

## Interface
- DW, 8: operand and result width (≥2)
- NUM_REG, 4: pipeline stages, equal to the unstalled latency (≥1)
- OCC_W, $clog2(NUM_REG+1): occupancy count width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active-low
- flush  in  1  synchronous clear of all in-flight transactions
- in_valid  in  1  operands valid
- in_ready  out  1  stage 1 can accept this cycle
- inp1  in  DW  operand A
- inp2  in  DW  operand B
- mode  in  2  00 wrap-unsigned, 01 sat-unsigned, 10 sat-signed, 11 wrap-signed
- out_valid  out  1  result valid (driven from the stage-NUM_REG valid bit)
- out_ready  in  1  consumer accepts result
- outp  out  DW  result
- out_ovf  out  1  overflow flag for the result
- occ  out  OCC_W  number of valid stages

## Operation
- Each stage i (1..NUM_REG) holds data[DW-1:0], ovf and valid_i.
- Stage i may load when ready_i is high: ready_i = !valid_i | ready_{i+1}, with ready_{NUM_REG+1} = out_ready.
  - This is a combinational chain from out_ready to in_ready; there are no bubbles and no skid buffers.
- in_ready = ready_1 & !flush & rst_n.
- Accept occurs when in_valid & in_ready.
- Stage 1 computes sum = inp1 + inp2 at DW+1 bits. The mode is used only in stage 1; it is not stored with the transaction.
  - 00: data = sum[DW-1:0]; ovf = sum[DW] (carry out).
  - 01: ovf = sum[DW]; data = ovf ? all-ones : sum[DW-1:0].
  - 10: ovf = signed overflow (operand signs equal and result sign differs); data = ovf ? (inp1[DW-1] ? 100..0 : 011..1) : sum[DW-1:0].
  - 11: data = sum[DW-1:0]; ovf = signed overflow.
- When ready_i is high for i>1, stage i loads from stage i-1, with valid_i ← valid_{i-1}.
- When ready_1 is high and there is no accept, valid_1 ← 0.
- When ready_i is low, stage i holds its data, ovf and valid.
- outp, out_ovf and out_valid are the stage-NUM_REG registers. They are held stable while out_valid & !out_ready.
- Flush:
  - On the edge where flush is high, all valid bits clear and occ becomes 0.
  - Data registers keep their values.
  - No accept is possible while flush is high.
  - Flush has priority over everything except reset.
- occ counts the set valid bits. It is registered and updated each edge:
  - +1 on accept, −1 on out_valid & out_ready, net 0 when both occur.
  - It never exceeds NUM_REG.

## Timing
- Reset (rst_n low, asynchronous): all valid bits, data, ovf, outp, out_ovf and occ are 0; out_valid=0; in_ready=0. After release, in_ready=1.
- Latency: a transaction accepted at edge k, with no stalls, has out_valid=1 after edge k+NUM_REG-1.
  - NUM_REG=1 means the result is visible in the cycle after acceptance.
- Throughput: 1 transaction per cycle while out_ready=1.
- Stall: while out_ready=0 the pipe compacts until every stage is valid; then in_ready=0.
  - When out_ready rises, in_ready rises in the same cycle, combinationally.
- Full pipe with out_ready=1: accept and drain happen on the same edge, and occ stays NUM_REG.
- Reset or flush mid-operation discards all in-flight results; no partial or duplicate outputs appear.
- in_valid, inp1, inp2 and mode are don't-care when in_ready=0.

## Test plan
- Reset, then stream 5 pairs with out_ready=1, mode=00, including 200+100: outputs in order, the first appearing 4 cycles after its accept; 200+100 gives outp=44 (0x2C), out_ovf=1.
- Modes on 0x70+0x20: mode 01 → 0x90, ovf=0; mode 10 → 0x7F, ovf=1; mode 11 → 0x90, ovf=1. Also 0x80+0xFF in mode 10 → 0x80, ovf=1.
- Hold out_ready=0 while driving continuous in_valid: exactly 4 accepts, then in_ready=0 and occ=4. Release out_ready: 4 results drain in order and in_ready=1 in the release cycle.
- Random in_valid/out_ready toggling over 1000 transactions against a scoreboard: no loss, duplication or reordering; outp/out_ovf stable while out_valid & !out_ready.
- Assert flush with occ=3: next cycle occ=0, out_valid=0, none of the 3 results ever appear; an accept in the following cycle completes normally.
- Drop rst_n asynchronously mid-stream with occ=2: outputs go to 0 immediately, in_ready=0; after release in_ready=1 and the next result matches its new inputs.
